od_line_ctrl: RTL
=================

# od_line_ctrl

Bit-slot sequencer for a single bidirectional open-drain pad on the iCE40 UltraPlus build, in the style of a 1-Wire master. It accepts one command at a time (line reset with presence detect, write bit, read bit) and times each slot by counting `clk` cycles. It drives the pad's output-enable, with the data-out tied low, so the line is only ever pulled low or released. It samples the pad input through a synchronizer and returns one response per command.

## Interface
Parameters (all in `clk` cycles; defaults for 12 MHz):
- `SLOT`, 840: total write/read slot length (70 µs).
- `W1_LOW`, 72: low time for write-1 and for read.
- `W0_LOW`, 720: low time for write-0.
- `SAMPLE`, 180: slot sample point, counted from the slot start. Includes the 2-cycle synchronizer lag.
- `RST_LOW`, 5760: reset low time.
- `PRES_SAMPLE`, 840: presence sample point, counted from the release.
- `RST_TOTAL`, 11520: total reset slot length.
- `REC`, 60: released recovery time after every slot.
- Legal parameter set: `W1_LOW` < `SAMPLE` < `SLOT`; `W0_LOW` < `SLOT`; `RST_LOW` + `PRES_SAMPLE` < `RST_TOTAL`; all ≥ 1.

Ports:
- `clk`, in, 1: sole clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_op`, in, 2: 00 = reset/presence, 01 = write, 10 = read, 11 = illegal.
- `cmd_bit`, in, 1: bit to write (used only by write).
- `rsp_valid`, out, 1: one-cycle response strobe.
- `rsp_bit`, out, 1: sampled line value. For reset it is the presence flag (1 = device pulled low).
- `rsp_err`, out, 1: stuck-low line, illegal op, or write collision.
- `pin_oe`, out, 1: 1 = pull pad low. Goes to pad `OUTPUTENABLE`; pad `DOUT0` is tied 0.
- `pin_in`, in, 1: pad `DIN0`; asynchronous.

## Operation
- States: IDLE, LOW, RELEASE, RECOVER.
- Reset values: state = IDLE, counter = 0, `pin_oe` = 0, `rsp_valid` = 0, `rsp_bit` = 0, `rsp_err` = 0, sample register = 1. Both synchronizer flops reset to 1.
- Accept: a command is accepted when `cmd_valid` && `cmd_ready`. At acceptance, `op` and `bit` are latched.
- Pre-check: if the synchronized line `line_s` is 0 at acceptance, or `op` = 11, the block does not drive the line. It returns to IDLE and pulses `rsp_valid` next cycle with `rsp_err` = 1 and `rsp_bit` = `line_s`.
- Otherwise the block enters LOW. Counter `cnt` = 0 on the first `pin_oe` cycle and increments every cycle through the slot.
- Low time:
  - `pin_oe` = 1 while `cnt` < `lowlen`.
  - `lowlen` = `RST_LOW` for reset, `W0_LOW` for write-0, `W1_LOW` for write-1 and read.
  - At `cnt` = `lowlen` the state moves to RELEASE.
- Sample: `line_s` is captured once, at `cnt` = `SAMPLE` for write/read, or at `cnt` = `RST_LOW` + `PRES_SAMPLE` for reset.
- Slot end: at `cnt` = `slotlen` − 1 (`SLOT` or `RST_TOTAL`) the state moves to RECOVER and the counter clears. RECOVER lasts `REC` cycles.
- Exit: on the last RECOVER cycle the state moves to IDLE. `rsp_valid` pulses on the IDLE entry cycle with:
  - Reset: `rsp_bit` = ~sample.
  - Write/read: `rsp_bit` = sample.
  - `rsp_err` = 1 only for write-1 sampled 0 (collision). For write-0 the sample is reported but never flagged.
- Back-to-back: a new command may be accepted in the same cycle `rsp_valid` pulses.
- `cmd_valid` outside IDLE is ignored; nothing is queued.

## Timing
- Accept-to-`pin_oe` latency: 1 cycle. `pin_oe` is registered, with no combinational path from inputs.
- Write/read command: acceptance to `rsp_valid` = 1 + `SLOT` + `REC` cycles. Reset command: 1 + `RST_TOTAL` + `REC` cycles.
- Pre-check error: `rsp_valid` 1 cycle after acceptance.
- `resetn` low mid-slot: `pin_oe` drops asynchronously, and no response is issued for the aborted command.
- Counter width: `$clog2(max(RST_TOTAL, SLOT, REC) + 1)`. It does not wrap within a slot.

## Structure
- Shared package `od_line_pkg`: op encoding constants (`OP_RESET`, `OP_WRITE`, `OP_READ`) and the state enum.
- Sub-module `sync_2ff`: 2-flop synchronizer, async active-low reset to a parameterised value (1 here).
- The instantiation top ties the pad's `DOUT0` = 0, `OUTPUTENABLE` = `pin_oe`, and `DIN0` → `pin_in`.

## Test plan
Bench runs with `SLOT`=20, `W1_LOW`=2, `W0_LOW`=15, `SAMPLE`=6, `RST_LOW`=40, `PRES_SAMPLE`=10, `RST_TOTAL`=80, `REC`=3. A pull-up model drives the line low when `pin_oe` = 1 or the device model pulls it.
- Write-1, no device: `pin_oe` high exactly cycles 1–2 after accept; `rsp_valid` at cycle 24; `rsp_bit` = 1, `rsp_err` = 0.
- Write-0: `pin_oe` high 15 cycles; `rsp_bit` = 0, `rsp_err` = 0.
- Read, device holds low cycles 0–10: `rsp_bit` = 0; repeat with no device → `rsp_bit` = 1.
- Reset with device presence pulse low at cnt 45–60: `rsp_bit` = 1 at cycle 84; without device → 0.
- Line held low before accept: `pin_oe` never asserts; `rsp_err` = 1 one cycle later. `op` = 11 gives the same response.
- `resetn` asserted at cnt 5 of write-0: `pin_oe` = 0 immediately, no `rsp_valid`; after release, `cmd_ready` = 1 and a back-to-back pair of commands completes normally.

Source files
------------

// File: rtl/od_line_pkg.sv
// rtl/od_line_pkg.sv - shared op encodings, state enum and helpers for the open-drain line sequencer
package od_line_pkg;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_RELEASE,
    ST_RECOVER
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with asynchronous active-low reset to a chosen level
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/od_line_ctrl.sv
// rtl/od_line_ctrl.sv - 1-Wire style bit-slot sequencer driving an open-drain pad via output-enable only
module od_line_ctrl
  import od_line_pkg::*;
#(
  parameter int SLOT        = 840,
  parameter int W1_LOW      = 72,
  parameter int W0_LOW      = 720,
  parameter int SAMPLE      = 180,
  parameter int RST_LOW     = 5760,
  parameter int PRES_SAMPLE = 840,
  parameter int RST_TOTAL   = 11520,
  parameter int REC         = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       rsp_err,
  output logic       pin_oe,
  input  logic       pin_in
);

  localparam int CNT_MAX = max3(RST_TOTAL, SLOT, REC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_W1_LOW   = CW'(W1_LOW);
  localparam logic [CW-1:0] C_W0_LOW   = CW'(W0_LOW);
  localparam logic [CW-1:0] C_RST_LOW  = CW'(RST_LOW);
  localparam logic [CW-1:0] C_SLOT_M1  = CW'(SLOT - 1);
  localparam logic [CW-1:0] C_RST_M1   = CW'(RST_TOTAL - 1);
  localparam logic [CW-1:0] C_SAMPLE   = CW'(SAMPLE);
  localparam logic [CW-1:0] C_PRES_PT  = CW'(RST_LOW + PRES_SAMPLE);
  localparam logic [CW-1:0] C_REC_M1   = CW'(REC - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic          bit_q;
  logic          sample_q;
  logic          pin_oe_q;
  logic          rsp_valid_q;
  logic          rsp_bit_q;
  logic          rsp_err_q;
  logic          line_s;

  logic [CW-1:0] lowlen_d;
  logic [CW-1:0] slot_end_d;
  logic [CW-1:0] samp_pt_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (pin_in),
    .q_o    (line_s)
  );

  // Slot geometry depends only on the latched command, so it is stable for the whole slot.
  always_comb begin
    lowlen_d   = C_W1_LOW;
    slot_end_d = C_SLOT_M1;
    samp_pt_d  = C_SAMPLE;
    if (op_q == OP_RESET) begin
      lowlen_d   = C_RST_LOW;
      slot_end_d = C_RST_M1;
      samp_pt_d  = C_PRES_PT;
    end else if (op_q == OP_WRITE && !bit_q) begin
      lowlen_d   = C_W0_LOW;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_RESET;
      bit_q       <= 1'b0;
      sample_q    <= 1'b1;
      pin_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            bit_q <= cmd_bit;
            cnt_q <= '0;
            // Never drive a line that is already low or for an undefined op.
            if (!line_s || cmd_op == 2'b11) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_bit_q   <= line_s;
            end else begin
              state_q  <= ST_LOW;
              pin_oe_q <= 1'b1;
            end
          end
        end
        ST_LOW, ST_RELEASE: begin
          if (cnt_q == samp_pt_d) begin
            sample_q <= line_s;
          end
          if (cnt_q == slot_end_d) begin
            state_q  <= ST_RECOVER;
            cnt_q    <= '0;
            pin_oe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (state_q == ST_LOW && (cnt_q + CW'(1)) == lowlen_d) begin
              state_q  <= ST_RELEASE;
              pin_oe_q <= 1'b0;
            end
          end
        end
        ST_RECOVER: begin
          if (cnt_q == C_REC_M1) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_bit_q   <= (op_q == OP_RESET) ? ~sample_q : sample_q;
            rsp_err_q   <= (op_q == OP_WRITE) && bit_q && !sample_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign pin_oe    = pin_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_err   = rsp_err_q;

endmodule
